// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and default width
// for the SPI master.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: divider counter, sck toggle and
// one-cycle tick/rise/fall strobes.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_run,
  input  logic             i_shift,
  output logic             o_tick,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_sck
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_sck;
  logic             w_hit;

  assign w_hit  = (r_cnt == r_div);
  assign o_tick = i_run & w_hit;
  assign o_rise = o_tick & i_shift & ~r_sck;
  assign o_fall = o_tick & i_shift & r_sck;
  assign o_sck  = r_sck;

  // Latch div once per transfer; reload count on every tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else begin
      if (i_start)
        r_div <= i_div;
      if (!i_run || o_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (o_rise)
        r_sck <= 1'b1;
      else if (o_fall || !i_shift)
        r_sck <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, MSB first by default.
// SPI_MASTER_LSB_FIRST_EN adds cmd_lsb_first.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DIV_W-1:0]  cmd_div,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic              cmd_lsb_first
`endif
);

  localparam int IDX_W = $clog2(DATA_W);

  spi_state_t        r_state;
  spi_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] w_rx_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_lsb;
  logic              r_mosi;
  logic              r_rsp_valid;
  logic              w_lsb_in;
  logic              w_accept;
  logic              w_tick;
  logic              w_rise;
  logic              w_fall;
  logic              w_last;
  logic              w_done;
  logic [LEN_W-1:0]  w_n;
  logic [IDX_W-1:0]  w_first_idx;
  logic [IDX_W-1:0]  w_nxt_idx;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_lsb_in = cmd_lsb_first;
`else
  assign w_lsb_in = 1'b0;
`endif

  assign cmd_ready = (r_state == IDLE) & ~r_rsp_valid;
  assign w_accept  = cmd_valid & cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rx;
  assign ss        = (r_state == IDLE);
  assign mosi      = r_mosi;

  assign w_n = (cmd_len == '0) ? LEN_W'(DATA_W)
                               : cmd_len;
  assign w_first_idx = w_lsb_in ? '0
                     : IDX_W'(w_n - LEN_W'(1));
  assign w_nxt_idx = r_lsb
                   ? IDX_W'(r_cnt + LEN_W'(1))
                   : IDX_W'(r_len - LEN_W'(2) - r_cnt);
  assign w_last = (r_cnt == r_len - LEN_W'(1));
  assign w_done = (r_state == HOLD) & w_tick;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clock   (clock),
    .resetn  (resetn),
    .i_start (w_accept),
    .i_div   (cmd_div),
    .i_run   (r_state != IDLE),
    .i_shift (r_state == SHIFT),
    .o_tick  (w_tick),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sck   (sck)
  );

  // Receive shift: MSB-first enters at bit 0,
  // LSB-first enters at bit len-1 and moves down.
  always_comb begin
    w_rx_nxt = {r_rx[DATA_W-2:0], miso};
    if (r_lsb) begin
      w_rx_nxt = r_rx >> 1;
      w_rx_nxt[IDX_W'(r_len - LEN_W'(1))] = miso;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = SETUP;
      SETUP: if (w_tick) w_state_nxt = SHIFT;
      SHIFT: if (w_fall && w_last)
               w_state_nxt = HOLD;
      HOLD:  if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch command, shift bits, hold response.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tx        <= '0;
      r_rx        <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_lsb       <= 1'b0;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx   <= cmd_data;
        r_rx   <= '0;
        r_len  <= w_n;
        r_cnt  <= '0;
        r_lsb  <= w_lsb_in;
        r_mosi <= cmd_data[w_first_idx];
      end
      if (w_rise)
        r_rx <= w_rx_nxt;
      if (w_fall) begin
        r_cnt <= r_cnt + LEN_W'(1);
        if (!w_last)
          r_mosi <= r_tx[w_nxt_idx];
      end
      if (w_done) begin
        r_mosi      <= 1'b0;
        r_rsp_valid <= 1'b1;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 16: maximum transfer length in bits and width of the data ports.
REQ-002 Parameter DIV_W, default 8: width of the clock-divider input.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_data  input  DATA_W  transmit word, right-aligned.
REQ-008 cmd_len  input  $clog2(DATA_W)+1  bit count per transfer; 0 means DATA_W.
REQ-009 cmd_div  input  DIV_W  SCK half-period equals cmd_div+1 clock cycles.
REQ-010 rsp_valid  output  1  received word available.
REQ-011 rsp_ready  input  1  consumer accepts the word.
REQ-012 rsp_data  output  DATA_W  received word, right-aligned, upper bits zero.
REQ-013 sck  output  1  SPI clock, idle low.
REQ-014 ss  output  1  slave select, active low.
REQ-015 mosi  output  1  serial data to the slave.
REQ-016 miso  input  1  serial data from the slave.

Function
REQ-017 SPI mode 0 only (CPOL=0, CPHA=0), MSB first: mosi changes while sck is low; miso is sampled into the shift register in the cycle sck rises.
REQ-018 Command handshake: cmd_ready = (state==IDLE) & !rsp_valid; accepted on cmd_valid & cmd_ready; data, len and div are latched at acceptance.
REQ-019 States:
- IDLE -> SETUP on command acceptance.
- SETUP -> SHIFT after div+1 cycles.
- SHIFT -> HOLD after len rising and len falling sck edges.
- HOLD -> IDLE after div+1 cycles, with rsp_valid set in the same cycle.
REQ-020 SETUP: ss low and mosi equal to bit len-1 of the latched data from the cycle after acceptance; sck stays low.
REQ-021 SHIFT: sck toggles every div+1 cycles. Each falling edge except the last presents the next lower bit on mosi. Each rising edge shifts miso into bit 0 of the receive register.
REQ-022 HOLD: sck low, ss low; at exit, ss returns high.
REQ-023 rsp_valid is held until rsp_valid & rsp_ready; rsp_data is stable while rsp_valid is asserted.
REQ-024 No new command is accepted while rsp_valid is high, so responses are never overwritten.
REQ-025 A transfer with cmd_div=0, len=N occupies ss low for exactly 2N+2 clock cycles.
REQ-026 cmd_valid while busy is ignored with no side effect; a rsp_ready that arrives with no pending response is ignored.
REQ-027 The divider counter reloads on every sck edge; div is never re-read mid-transfer.
REQ-028 mosi is 0 and sck is 0 whenever ss is high.

Reset
REQ-029 resetn low forces these values immediately, including mid-transfer:
- state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0
- sck 0, ss 1, mosi 0
- all counters and shift registers 0
REQ-030 Release of resetn takes effect on the next rising clock edge; no partial transfer resumes.

Configuration
REQ-031 Macro SPI_MASTER_LSB_FIRST_EN.
- Defined: the module adds an input cmd_lsb_first (1 bit), latched at acceptance; when it is 1, transmit order is bit 0 upward and received bits fill from bit len-1 downward, so rsp_data stays right-aligned in natural order.
- Undefined: the port is absent and the order is always MSB first.

Structure
REQ-032 Package spi_pkg holds the state enum type (IDLE, SETUP, SHIFT, HOLD) and the localparam for the default DATA_W; no other shared items.
REQ-033 One sub-module, spi_clkgen, SHALL hold the divider counter and sck toggle and issue one-cycle rise and fall strobes; spi_master holds the FSM and the shift registers.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Loopback (miso tied to mosi), len=8, div=0, data=0xA5 -> rsp_data=0x00A5; ss low for 18 cycles; 8 sck pulses.
- Slave model returns the bit-reversed byte in a second 8-bit transfer after a first transfer of 0x01 -> rsp_data=0x0080.
- len=0, div=3, data=0x8001 -> 16 sck pulses, each 4 cycles high and 4 cycles low; mosi is 1 on the first and last bits only.
- rsp_ready held low for 10 cycles after completion, with cmd_valid high throughout -> cmd_ready stays 0, rsp_data is stable, and the second command starts the cycle after the handshake.
- resetn pulsed low at the 3rd rising sck edge of a transfer -> ss=1, sck=0 and rsp_valid=0 in the same cycle; a following command completes normally.
- With SPI_MASTER_LSB_FIRST_EN defined, loopback, len=4, data=0x3, lsb_first=1 -> mosi sequence 1,1,0,0 and rsp_data=0x3.
